// File: rtl/usb_ep_pkg.sv
// Shared definitions for the bulk IN endpoint.
//   ep_state_t      : packet FSM states (idle, streaming a packet, sending a
//                     zero-length packet, waiting for the host handshake).
//   USB_*_BULK_MPS  : standard bulk max-packet sizes (full speed / high speed).
package usb_ep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ZLP  = 2'd2,
    ST_WAIT = 2'd3
  } ep_state_t;

  localparam int USB_FS_BULK_MPS = 64;
  localparam int USB_HS_BULK_MPS = 512;

endpackage

// File: rtl/sync_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clock : clock for both ports
//   we    : write enable; wdata is stored at waddr
//   re    : read enable; rdata loads mem[raddr] on the next edge and
//           holds its value while re is low
module sync_dpram #(
  parameter int WIDTH  = 9,
  parameter int AWIDTH = 11
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [1 << AWIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bulk_ep_in_pkt.sv
// Bulk IN endpoint buffer. Buffers an AXI-Stream byte stream and hands it to
// the USB protocol layer as packets of at most MAX_PACKET bytes. A packet stays
// in the buffer until ACKed so it can be resent; a ZLP follows a transfer that
// ends exactly on a packet boundary (when ENABLE_ZLP is set).
//   clock, reset_n      : clock, asynchronous active-low reset
//   s_t*                : application byte stream in
//   status_full_o       : registered copy of ~s_tready_o
//   ep_has_data_o       : a packet or ZLP is ready (only asserted in idle)
//   ep_start_i          : IN token accepted, start a packet
//   ep_ack_i/ep_retry_i : host ACKed / no ACK, rewind
//   ep_zlp_o            : current packet is zero-length (one-cycle pulse)
//   m_t*                : packet byte stream out
// Handshake: on both streams a byte transfers on a clock edge where valid and
// ready are both high; valid never depends on ready, and once valid is high
// the data/last lines hold until the transfer happens.
module bulk_ep_in_pkt
  import usb_ep_pkg::*;
#(
  parameter int MAX_PACKET = USB_HS_BULK_MPS,
  parameter int ABITS      = 11,
  parameter int ENABLE_ZLP = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       status_full_o,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  input  logic       s_tlast_i,
  input  logic [7:0] s_tdata_i,
  output logic       ep_has_data_o,
  input  logic       ep_start_i,
  input  logic       ep_ack_i,
  input  logic       ep_retry_i,
  output logic       ep_zlp_o,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o
);

  localparam int              CW       = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
  localparam logic [ABITS:0]  DEPTH_P  = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0]  MAX_P    = (ABITS+1)'(MAX_PACKET);
  localparam logic [ABITS:0]  ONE_P    = (ABITS+1)'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_PACKET - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  ep_state_t       state, state_nxt;
  logic [ABITS:0]  wr_ptr, rd_ptr, cm_ptr;
  logic [ABITS:0]  wr_nxt, rd_nxt, cm_nxt, level, level_nxt;
  logic [ABITS:0]  last_cnt, last_cnt_nxt;
  logic            zlp_pend, zlp_pend_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pkt_full, pkt_full_nxt;
  logic            pkt_last, pkt_last_nxt;
  logic            pkt_zlp, pkt_zlp_nxt;
  logic            out_valid, out_valid_nxt;
  logic            wr_en, last_inc, last_dec;
  logic            re, hs, beat_last, has_nxt;
  logic [ABITS-1:0] rd_addr;
  logic [8:0]      rdata;

  // Space is only reclaimed on commit, so fullness is measured against cm.
  assign level      = wr_ptr - cm_ptr;
  assign s_tready_o = (level != DEPTH_P);
  assign wr_en      = s_tvalid_i & s_tready_o;
  assign wr_nxt     = wr_en ? wr_ptr + ONE_P : wr_ptr;
  assign last_inc   = wr_en & s_tlast_i;

  sync_dpram #(
    .WIDTH  (9),
    .AWIDTH (ABITS)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr[ABITS-1:0]),
    .wdata ({s_tlast_i, s_tdata_i}),
    .re    (re),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  // The RAM read register is the single output stage; out_valid marks it
  // occupied. rd_ptr always addresses the byte currently presented.
  assign hs         = out_valid & m_tready_i;
  assign beat_last  = rdata[8] | (cnt == CNT_LAST);
  assign m_tvalid_o = out_valid;
  assign m_tlast_o  = out_valid & beat_last;
  assign m_tdata_o  = out_valid ? rdata[7:0] : 8'h00;
  assign ep_zlp_o   = (state == ST_ZLP);

  always_comb begin
    state_nxt     = state;
    rd_nxt        = rd_ptr;
    cm_nxt        = cm_ptr;
    cnt_nxt       = cnt;
    pkt_full_nxt  = pkt_full;
    pkt_last_nxt  = pkt_last;
    pkt_zlp_nxt   = pkt_zlp;
    zlp_pend_nxt  = zlp_pend;
    last_dec      = 1'b0;
    re            = 1'b0;
    rd_addr       = rd_ptr[ABITS-1:0];
    case (state)
      ST_IDLE: begin
        if (ep_start_i) begin
          if (zlp_pend) begin
            state_nxt    = ST_ZLP;
            rd_nxt       = cm_ptr;
            pkt_zlp_nxt  = 1'b1;
            pkt_full_nxt = 1'b0;
            pkt_last_nxt = 1'b0;
          end else if (ep_has_data_o) begin
            state_nxt   = ST_SEND;
            rd_nxt      = cm_ptr;
            cnt_nxt     = '0;
            pkt_zlp_nxt = 1'b0;
          end
        end
      end
      ST_SEND: begin
        // Prefetch the next byte while the current one is being taken,
        // but never read past the end of the packet.
        re      = ~out_valid | (m_tready_i & ~beat_last);
        rd_addr = hs ? rd_ptr[ABITS-1:0] + ABITS'(1) : rd_ptr[ABITS-1:0];
        if (hs) begin
          rd_nxt  = rd_ptr + ONE_P;
          cnt_nxt = cnt + CNT_ONE;
          if (beat_last) begin
            pkt_full_nxt = (cnt == CNT_LAST);
            pkt_last_nxt = rdata[8];
            state_nxt    = ST_WAIT;
          end
        end
      end
      ST_ZLP: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ep_ack_i) begin
          cm_nxt   = rd_ptr;
          last_dec = pkt_last;
          if ((ENABLE_ZLP != 0) && pkt_full && pkt_last) zlp_pend_nxt = 1'b1;
          if (pkt_zlp) zlp_pend_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end else if (ep_retry_i) begin
          rd_nxt    = cm_ptr;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    last_cnt_nxt = last_cnt;
    if (last_inc && !last_dec)      last_cnt_nxt = last_cnt + ONE_P;
    else if (!last_inc && last_dec) last_cnt_nxt = last_cnt - ONE_P;
  end

  assign out_valid_nxt = re | (out_valid & ~m_tready_i);

  // has_data is evaluated on next-cycle values so it follows a write or
  // commit by exactly one cycle.
  assign level_nxt = wr_nxt - cm_nxt;
  assign has_nxt   = (state_nxt == ST_IDLE) &
                     ((level_nxt >= MAX_P) | (last_cnt_nxt != '0) | zlp_pend_nxt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cm_ptr        <= '0;
      last_cnt      <= '0;
      zlp_pend      <= 1'b0;
      cnt           <= '0;
      pkt_full      <= 1'b0;
      pkt_last      <= 1'b0;
      pkt_zlp       <= 1'b0;
      out_valid     <= 1'b0;
      ep_has_data_o <= 1'b0;
      status_full_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_nxt;
      rd_ptr        <= rd_nxt;
      cm_ptr        <= cm_nxt;
      last_cnt      <= last_cnt_nxt;
      zlp_pend      <= zlp_pend_nxt;
      cnt           <= cnt_nxt;
      pkt_full      <= pkt_full_nxt;
      pkt_last      <= pkt_last_nxt;
      pkt_zlp       <= pkt_zlp_nxt;
      out_valid     <= out_valid_nxt;
      ep_has_data_o <= has_nxt;
      status_full_o <= ~s_tready_o;
    end
  end

endmodule

// File: tb/tb_bulk_ep_in_pkt.sv
// Testbench for bulk_ep_in_pkt (MAX_PACKET=64, 64-byte FIFO). A second
// instance with ENABLE_ZLP=0 shares all inputs and must never pulse ep_zlp_o.
module tb_bulk_ep_in_pkt;

  localparam int MAXP  = 64;
  localparam int AB    = 6;
  localparam int DEPTH = 64;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tvalid_i, s_tlast_i;
  logic [7:0] s_tdata_i;
  logic       ep_start_i, ep_ack_i, ep_retry_i, m_tready_i;
  logic       status_full_o, s_tready_o, ep_has_data_o, ep_zlp_o;
  logic       m_tvalid_o, m_tlast_o;
  logic [7:0] m_tdata_o;
  logic       nz_full, nz_ready, nz_has, nz_zlp, nz_valid, nz_last;
  logic [7:0] nz_data;

  always #5 clock = ~clock;

  bulk_ep_in_pkt #(.MAX_PACKET(MAXP), .ABITS(AB), .ENABLE_ZLP(1)) dut (
    .clock(clock), .reset_n(reset_n), .status_full_o(status_full_o),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
    .s_tdata_i(s_tdata_i), .ep_has_data_o(ep_has_data_o), .ep_start_i(ep_start_i),
    .ep_ack_i(ep_ack_i), .ep_retry_i(ep_retry_i), .ep_zlp_o(ep_zlp_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .m_tdata_o(m_tdata_o)
  );

  bulk_ep_in_pkt #(.MAX_PACKET(MAXP), .ABITS(AB), .ENABLE_ZLP(0)) dut_nz (
    .clock(clock), .reset_n(reset_n), .status_full_o(nz_full),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(nz_ready), .s_tlast_i(s_tlast_i),
    .s_tdata_i(s_tdata_i), .ep_has_data_o(nz_has), .ep_start_i(ep_start_i),
    .ep_ack_i(ep_ack_i), .ep_retry_i(ep_retry_i), .ep_zlp_o(nz_zlp),
    .m_tvalid_o(nz_valid), .m_tready_i(m_tready_i), .m_tlast_o(nz_last),
    .m_tdata_o(nz_data)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] wr_q[$];     // bytes still to be written {last, data}
  logic [8:0] store_q[$];  // accepted, uncommitted bytes (reference model)
  logic [9:0] exp_q[$];    // expected output: {zlp, last, data}

  bit zlp_pend_m = 1'b0;
  bit tready_rand = 1'b0;
  int zlp_seen = 0, nz_zlp_seen = 0, pkts_seen = 0;
  int cur_len;
  bit cur_zlp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock); #1;
  endtask

  // ---------------- model ----------------
  function automatic bit model_has();
    if (zlp_pend_m) return 1'b1;
    if (store_q.size() >= MAXP) return 1'b1;
    foreach (store_q[i]) if (store_q[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_len();
    for (int i = 0; i < store_q.size() && i < MAXP; i++)
      if (store_q[i][8]) return i + 1;
    return MAXP;
  endfunction

  task automatic queue_transfer(input int len, input bit with_last);
    for (int i = 0; i < len; i++)
      wr_q.push_back({(with_last && i == len - 1), 8'($urandom_range(0, 255))});
  endtask

  // ---------------- stream writer ----------------
  initial begin : writer
    bit rdy, acc;
    rdy = 1'b0;
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = 8'h00;
    forever begin
      @(posedge clock); #1;
      acc = s_tvalid_i && rdy && reset_n;
      if (acc) begin
        store_q.push_back({s_tlast_i, s_tdata_i});
        void'(wr_q.pop_front());
      end
      if (!(s_tvalid_i && !acc && wr_q.size() > 0)) begin
        if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          s_tvalid_i = 1'b1;
          {s_tlast_i, s_tdata_i} = wr_q[0];
        end else begin
          s_tvalid_i = 1'b0;
          s_tlast_i  = 1'b0;
        end
      end
      @(negedge clock);
      rdy = s_tready_o;
    end
  end

  // ---------------- sink ready ----------------
  initial begin : sink
    m_tready_i = 1'b1;
    forever begin
      @(posedge clock); #1;
      m_tready_i = tready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    bit prev_stall;
    logic [8:0] prev_beat;
    logic [9:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (nz_zlp) nz_zlp_seen++;
      if (prev_stall) begin
        check("hold_valid", m_tvalid_o, 1);
        check("hold_beat", {m_tlast_o, m_tdata_o}, prev_beat);
      end
      if (ep_zlp_o) begin
        zlp_seen++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        check("zlp", {ep_zlp_o, m_tvalid_o, 8'h00}, e);
      end
      if (m_tvalid_o && m_tready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        check("beat", {1'b0, m_tlast_o, m_tdata_o}, e);
        if (m_tlast_o) pkts_seen++;
      end
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_beat  = {m_tlast_o, m_tdata_o};
    end
  end

  // ---------------- protocol-layer driver ----------------
  task automatic start_pkt(output bit started);
    started = 1'b0;
    check("has_data", ep_has_data_o, model_has());
    check("s_tready", s_tready_o, store_q.size() < DEPTH);
    if (!model_has()) return;
    started = 1'b1;
    if (zlp_pend_m) begin
      cur_zlp = 1'b1;
      cur_len = 0;
      exp_q.push_back(10'h200);
    end else begin
      cur_zlp = 1'b0;
      cur_len = model_len();
      for (int i = 0; i < cur_len; i++)
        exp_q.push_back({1'b0, (i == cur_len - 1), store_q[i][7:0]});
    end
    ep_start_i = 1'b1;
    tick();
    ep_start_i = 1'b0;
    if (cur_zlp) begin
      check("zlp_timing", ep_zlp_o, 1);
    end else begin
      check("first_valid_early", m_tvalid_o, 0);
      tick();
      check("first_valid", m_tvalid_o, 1);
    end
  endtask

  // action: 0 ack, 1 retry, 2 ack+retry together
  task automatic finish_pkt(input int action);
    int n;
    bit last;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("pkt_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat ($urandom_range(1, 3)) tick();
    ep_ack_i   = (action != 1);
    ep_retry_i = (action != 0);
    tick();
    ep_ack_i   = 1'b0;
    ep_retry_i = 1'b0;
    if (action != 1) begin
      last = cur_zlp ? 1'b0 : store_q[cur_len-1][8];
      for (int i = 0; i < cur_len; i++) void'(store_q.pop_front());
      if (cur_zlp) zlp_pend_m = 1'b0;
      else if (cur_len == MAXP && last) zlp_pend_m = 1'b1;
    end
    check("has_data_after", ep_has_data_o, model_has());
    check("s_tready_after", s_tready_o, store_q.size() < DEPTH);
  endtask

  task automatic send_pkt(input int action);
    bit st;
    start_pkt(st);
    if (st) finish_pkt(action);
  endtask

  task automatic drain(input bit stop_at_zlp, input bit rand_action);
    int waited;
    waited = 0;
    forever begin
      if (stop_at_zlp && zlp_pend_m) break;
      if (model_has()) begin
        send_pkt(rand_action ? (($urandom_range(0, 5) < 4) ? 0 : $urandom_range(1, 2)) : 0);
      end else if (wr_q.size() == 0) begin
        break;
      end else begin
        tick();
        waited++;
        if (waited > 20000) begin
          check("drain_timeout", wr_q.size(), 0);
          break;
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_tready"}, s_tready_o, 1);
    check({tag, "_status_full"}, status_full_o, 0);
    check({tag, "_has_data"}, ep_has_data_o, 0);
    check({tag, "_zlp"}, ep_zlp_o, 0);
    check({tag, "_m_tvalid"}, m_tvalid_o, 0);
    check({tag, "_m_tlast"}, m_tlast_o, 0);
    check({tag, "_m_tdata"}, m_tdata_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int p0, z0, n;
    bit st;
    ep_start_i = 1'b0; ep_ack_i = 1'b0; ep_retry_i = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // single short transfer
    p0 = pkts_seen;
    queue_transfer(10, 1'b1);
    drain(1'b0, 1'b0);
    check("short_pkts", pkts_seen - p0, 1);
    check("short_has_data", ep_has_data_o, 0);
    check("short_ready", s_tready_o, 1);

    // exact multiple of the packet size: two packets then a ZLP
    p0 = pkts_seen;
    z0 = zlp_seen;
    queue_transfer(128, 1'b1);
    drain(1'b1, 1'b0);
    check("exact_pkts", pkts_seen - p0, 2);
    check("exact_has_data", ep_has_data_o, 1);
    check("exact_nz_has_data", nz_has, 0);
    send_pkt(0);
    check("exact_zlps", zlp_seen - z0, 1);
    check("exact_idle", ep_has_data_o, 0);

    // retry resends the same bytes, ack then moves on
    queue_transfer(100, 1'b1);
    n = 0;
    while (store_q.size() < MAXP && n < 2000) begin tick(); n++; end
    check("retry_fill", store_q.size() >= MAXP, 1);
    send_pkt(1);
    send_pkt(0);
    drain(1'b0, 1'b0);

    // full FIFO
    queue_transfer(64, 1'b0);
    n = 0;
    while (wr_q.size() > 0 && n < 2000) begin tick(); n++; end
    check("full_ready", s_tready_o, 0);
    check("full_flag_early", status_full_o, 0);
    tick();
    check("full_flag", status_full_o, 1);
    send_pkt(0);
    check("full_ready_after_ack", s_tready_o, 1);
    tick();
    check("full_flag_after_ack", status_full_o, 0);

    // randomized transfers with backpressure and mixed ack/retry strobes
    tready_rand = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t % 4 == 0) queue_transfer(MAXP * $urandom_range(1, 2), 1'b1);
      else            queue_transfer($urandom_range(1, 150), 1'b1);
      drain(1'b0, 1'b1);
    end

    // reset in the middle of a packet
    queue_transfer(40, 1'b1);
    n = 0;
    while (wr_q.size() > 0 && n < 2000) begin tick(); n++; end
    start_pkt(st);
    n = 0;
    while (exp_q.size() > cur_len - 5 && n < 2000) begin tick(); n++; end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("midsend");
    exp_q.delete();
    store_q.delete();
    zlp_pend_m = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_has_data", ep_has_data_o, 0);
    check("post_reset_ready", s_tready_o, 1);

    // buffer is empty afterwards: the next packet is exactly the new bytes
    tready_rand = 1'b0;
    p0 = pkts_seen;
    queue_transfer(20, 1'b1);
    drain(1'b0, 1'b0);
    check("post_reset_pkts", pkts_seen - p0, 1);

    check("nz_no_zlp", nz_zlp_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bulk_ep_in_pkt.md
# bulk_ep_in_pkt

Single-clock, parametrised bulk IN endpoint buffer. It accepts an AXI-Stream byte stream, stores it in a local FIFO and splits it into USB packets of at most `MAX_PACKET` bytes. A packet is held in the buffer until the host ACKs it, so the protocol layer can retransmit it after a timeout or error. A zero-length packet (ZLP) is generated when a transfer ends exactly on a packet boundary. It sits between the application stream and the USB protocol/transaction layer.

## Interface
- `MAX_PACKET`, 512: max packet size in bytes; power of 2, ≤ 2^`ABITS`.
- `ABITS`, 11: FIFO address bits; depth is 2^`ABITS` bytes.
- `ENABLE_ZLP`, 1: 1 enables ZLP generation; 0 never sends a ZLP.
- `clock` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `status_full_o` out 1: registered `~s_tready_o`.
- `s_tvalid_i` in 1: application stream valid.
- `s_tready_o` out 1: high when the FIFO is not full.
- `s_tlast_i` in 1: end of transfer.
- `s_tdata_i` in 8: data byte.
- `ep_has_data_o` out 1: a packet or ZLP is ready to send (registered).
- `ep_start_i` in 1: one-cycle pulse; the IN token has been accepted by the protocol layer.
- `ep_ack_i` in 1: one-cycle pulse; the host ACKed the last packet.
- `ep_retry_i` in 1: one-cycle pulse; no ACK was received, so rewind and resend.
- `ep_zlp_o` out 1: one-cycle pulse; the current packet is zero-length.
- `m_tvalid_o` out 1: packet data valid.
- `m_tready_i` in 1: packet data ready.
- `m_tlast_o` out 1: last byte of the packet.
- `m_tdata_o` out 8: packet data byte.

## Operation
- **Storage.** The memory is 9 bits wide: the data byte plus its `tlast` flag.
- **Pointers.** There are three pointers, each `ABITS+1` bits wide: `wr`, `rd` (speculative read) and `cm` (commit).
  - Full when `wr - cm == 2^ABITS`.
  - Bytes only become free space on commit.
- **`last_cnt`.** Counts stored, uncommitted bytes that carry `tlast`.
  - Increments on a write with `tlast`.
  - Decrements when a committed packet ended on a `tlast` byte.
  - Simultaneous increment and decrement leave it unchanged.
- **`ep_has_data_o`** is computed in IDLE only, as (`wr-cm ≥ MAX_PACKET`) | (`last_cnt≠0`) | `zlp_pend`. It is forced low outside IDLE.
- **State IDLE:**
  - `ep_start_i` with `zlp_pend` set → go to ZLP. A pending ZLP takes priority over data queued after it.
  - Otherwise `ep_start_i` with `ep_has_data_o` set → go to SEND, clear the byte counter, set `rd = cm`.
  - `ep_start_i` with no data is ignored (the protocol layer NAKs).
- **State SEND:**
  - Stream bytes from `rd`; increment `rd` and the counter on each handshake.
  - `m_tlast_o` = stored `tlast` | (counter == `MAX_PACKET-1`).
  - On the last beat: latch `pkt_full` (counter == `MAX_PACKET-1`) and `pkt_last` (stored `tlast`), then go to WAIT.
- **State ZLP:** pulse `ep_zlp_o` for one cycle with no `m_tvalid_o`, then go to WAIT.
- **State WAIT:**
  - `ep_ack_i` → set `cm = rd`.
    - If `pkt_last`, decrement `last_cnt`.
    - If `ENABLE_ZLP & pkt_full & pkt_last`, set `zlp_pend`.
    - If the packet was a ZLP, clear `zlp_pend`.
    - Go to IDLE.
  - `ep_retry_i` → set `rd = cm`, go to IDLE. The next `ep_start_i` resends identical bytes.
  - `ep_ack_i` and `ep_retry_i` together: ack wins.
- **Ignored strobes.** `ep_ack_i` and `ep_retry_i` outside WAIT are ignored.
- **Inputs during SEND/WAIT.** Writes continue in SEND and WAIT.
- **Reset.** Asserting reset mid-packet discards everything: all pointers are 0 and the state is IDLE.

## Timing
- **Reset values:** `s_tready_o`=1, `status_full_o`=0, `ep_has_data_o`=0, `ep_zlp_o`=0, `m_tvalid_o`=0, `m_tlast_o`=0, `m_tdata_o`=0.
- **Memory read:** synchronous, 1 cycle, with a one-entry output register and prefetch.
  - The first `m_tvalid_o` is asserted 2 cycles after the `ep_start_i` cycle.
  - After that, one byte per cycle while `m_tready_i` is high.
- **Output hold:** `m_tdata_o`, `m_tlast_o` and `m_tvalid_o` are held stable while `m_tvalid_o & ~m_tready_i`.
- **`ep_has_data_o` latency:** 1 cycle after the qualifying write or commit.
- **`ep_zlp_o`:** asserted exactly 1 cycle after `ep_start_i`.
- **Freed space:** commit frees space on the cycle after `ep_ack_i`, so `s_tready_o` can rise that cycle.

## Structure
- **Package `usb_ep_pkg`:** state encoding (IDLE, SEND, ZLP, WAIT) and the USB packet size constants (64 / 512).
- **Sub-module `sync_dpram`:** 1 write port, 1 registered read port, width and depth parameters. Pointers and the FSM stay in this block.

## Test plan
- **Single short transfer:** write 10 bytes with `tlast` on byte 10, then `ep_start_i` → one packet of 10 bytes with `m_tlast_o` on byte 10. After `ep_ack_i`: `ep_has_data_o`=0 and level 0.
- **Exact-multiple transfer:** `MAX_PACKET`=64, write 128 bytes with `tlast` on byte 128 → two 64-byte packets, then `ep_has_data_o`=1 and the next start gives an `ep_zlp_o` pulse. Repeat with `ENABLE_ZLP`=0 → no ZLP.
- **Retry:** send a 64-byte packet and pulse `ep_retry_i` → the next start resends the same 64 bytes in order. Then `ep_ack_i` advances to bytes 65+.
- **Full FIFO:** `ABITS`=6, write 64 bytes with no `tlast` → `s_tready_o`=0 and `status_full_o`=1 one cycle later. After the packet is ACKed, `s_tready_o`=1.
- **Backpressure, simultaneous strobes and reset:**
  - Random `m_tready_i` → data is held stable and no byte is lost or duplicated.
  - `ep_ack_i` and `ep_retry_i` in the same cycle → treated as ack.
  - `reset_n` low mid-SEND → every output is at its reset value immediately (asynchronously) and the FIFO is empty.
